// File: rtl/inc16.sv
// 16-bit incrementer: a combinational ripple half-adder chain plus an optional
// registered copy of the result (out_q/cout_q) and a one-cycle capture strobe.
module inc16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic [WIDTH-1:0] out_q,
    output logic             cout_q,
    output logic             valid_q
);

    // Carry out of each stage; carry[WIDTH-1] is the final carry out.
    logic [WIDTH-1:0] carry;

    // Next-state values for the registered path.
    logic [WIDTH-1:0] out_d;
    logic             cout_d;
    logic             valid_d;

    // Stage 0: a half adder whose second operand is the constant 1.
    assign out[0]   = ~in[0];
    assign carry[0] = in[0];

    // Stages 1..WIDTH-1: one half adder per bit, chained through carry.
    for (genvar i = 1; i < WIDTH; i++) begin : g_ha
        assign out[i]   = in[i] ^ carry[i-1];
        assign carry[i] = in[i] & carry[i-1];
    end

    assign cout = carry[WIDTH-1];

    // Capture on en, otherwise hold result; valid pulses only after a capture.
    always_comb begin
        out_d   = out_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        if (en) begin
            out_d   = out;
            cout_d  = cout;
            valid_d = 1'b1;
        end
    end

    // Registered copy; reset clears it immediately and overrides any capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_inc16.sv
// Self-checking bench for inc16: vector table, ripple and exhaustive sweeps,
// hand-written register sequences and a randomized run against a model.
module tb_inc16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        en = 1'b0;
    logic [15:0] out;
    logic        cout;
    logic [15:0] out_q;
    logic        cout_q;
    logic        valid_q;

    int checks = 0;
    int errors = 0;

    inc16 #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .en      (en),
        .out     (out),
        .cout    (cout),
        .out_q   (out_q),
        .cout_q  (cout_q),
        .valid_q (valid_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vin;
        logic [15:0] exp_out;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[10];

    // Reference: unsigned 17-bit sum of in and 1.
    function automatic logic [16:0] ref_inc(input logic [15:0] v);
        ref_inc = {1'b0, v} + 17'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [15:0] m_out;
    logic        m_cout;
    logic        m_valid;
    logic [16:0] r;
    int          sweep_bad;

    initial begin
        vecs[0] = '{16'h3524, 16'h3525, 1'b0};
        vecs[1] = '{16'h5E81, 16'h5E82, 1'b0};
        vecs[2] = '{16'hD609, 16'hD60A, 1'b0};
        vecs[3] = '{16'h5663, 16'h5664, 1'b0};
        vecs[4] = '{16'h0000, 16'h0001, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h8000, 1'b0};
        vecs[6] = '{16'hFFFE, 16'hFFFF, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0000, 1'b1};
        vecs[8] = '{16'h00FF, 16'h0100, 1'b0};
        vecs[9] = '{16'h0FFF, 16'h1000, 1'b0};

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_out_q", {16'h0, out_q}, 32'h0);
        check("rst_cout_q", {31'h0, cout_q}, 32'h0);
        check("rst_valid_q", {31'h0, valid_q}, 32'h0);

        // Combinational vectors, reset held and en low.
        for (int i = 0; i < 10; i++) begin
            in = vecs[i].vin;
            #10;
            check($sformatf("vec%0d_out", i), {16'h0, out}, {16'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_cout", i), {31'h0, cout}, {31'h0, vecs[i].exp_cout});
        end
        check("reset_holds_out_q", {16'h0, out_q}, 32'h0);

        // Exhaustive sweep against the reference sum.
        sweep_bad = 0;
        for (int v = 0; v < 65536; v++) begin
            in = v[15:0];
            #1;
            r = ref_inc(v[15:0]);
            if ({cout, out} !== r) begin
                sweep_bad++;
                if (sweep_bad <= 4) check($sformatf("sweep_%h", v[15:0]), {15'h0, cout, out}, {15'h0, r});
            end
        end
        check("sweep_bad_count", sweep_bad, 0);

        // Registered capture of the wrap case.
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        in    = 16'hFFFF;
        @(posedge clk); #1;
        check("cap_out_q", {16'h0, out_q}, 32'h0);
        check("cap_cout_q", {31'h0, cout_q}, 32'h1);
        check("cap_valid_q", {31'h0, valid_q}, 32'h1);
        @(negedge clk);
        en = 1'b0;
        in = 16'h4321;
        @(posedge clk); #1;
        check("hold_out_q", {16'h0, out_q}, 32'h0);
        check("hold_cout_q", {31'h0, cout_q}, 32'h1);
        check("hold_valid_q", {31'h0, valid_q}, 32'h0);

        // Capture 1235, then reset between edges.
        @(negedge clk);
        en = 1'b1;
        in = 16'h1234;
        @(posedge clk); #1;
        check("cap2_out_q", {16'h0, out_q}, 32'h1235);
        #2 reset = 1'b1;
        #1;
        check("async_out_q", {16'h0, out_q}, 32'h0);
        check("async_cout_q", {31'h0, cout_q}, 32'h0);
        check("async_valid_q", {31'h0, valid_q}, 32'h0);
        check("async_comb_out", {16'h0, out}, 32'h1235);
        @(posedge clk); #1;
        check("rst_blocks_cap", {16'h0, out_q}, 32'h0);

        // Randomized run against a behavioural model of the register.
        m_out = 16'h0; m_cout = 1'b0; m_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            in    = 16'($urandom);
            en    = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 19) == 0);
            #1;
            r = ref_inc(in);
            check("rnd_out", {16'h0, out}, {16'h0, r[15:0]});
            check("rnd_cout", {31'h0, cout}, {31'h0, r[16]});
            if (reset) begin
                m_out = 16'h0; m_cout = 1'b0; m_valid = 1'b0;
            end else if (en) begin
                m_out = r[15:0]; m_cout = r[16]; m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("rnd_out_q", {16'h0, out_q}, {16'h0, m_out});
            check("rnd_cout_q", {31'h0, cout_q}, {31'h0, m_cout});
            check("rnd_valid_q", {31'h0, valid_q}, {31'h0, m_valid});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
